// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples bit_clk/frame_clk/data_in in clk and publishes stereo pairs.
// Optional 8-bit saturating error counter output is enabled with `define I2S_RX_ERR_CNT_EN.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int MAX_SLOT     = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bit_clk,
    input  logic                    frame_clk,
    input  logic                    data_in,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    output logic                    frame_error,
`ifdef I2S_RX_ERR_CNT_EN
    output logic [7:0]              err_count,
`endif
    output logic                    short_slot
);
    localparam int CW = $clog2(MAX_SLOT + 1);
    localparam logic [CW-1:0] SW_C  = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_SLOT);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;
    state_t r_state, w_state_nxt;

    logic r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic r_lr_s1, r_lr_s2, r_lr_prev;
    logic r_din_s1, r_din_s2;
    logic [SAMPLE_WIDTH-1:0] r_shift, r_left_hold, r_sample_left, r_sample_right;
    logic [CW-1:0] r_cnt;
    logic r_valid, r_ferr, r_short;

    logic w_rise, w_lr_chg, w_take, w_short, w_overrun;
    logic [SAMPLE_WIDTH-1:0] w_shift_in, w_word;
    logic [CW-1:0] w_cnt_inc;
    logic [SAMPLE_WIDTH-1:0] w_shift_nxt, w_hold_nxt, w_sl_nxt, w_sr_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic w_valid_nxt, w_ferr_nxt, w_short_evt;

    assign w_rise     = r_bclk_s2 & ~r_bclk_d;
    assign w_lr_chg   = r_lr_s2 ^ r_lr_prev;
    assign w_take     = r_cnt < SW_C;
    assign w_shift_in = w_take ? {r_shift[SAMPLE_WIDTH-2:0], r_din_s2} : r_shift;
    assign w_cnt_inc  = (r_cnt == MAX_C) ? r_cnt : r_cnt + 1'b1;
    assign w_short    = w_cnt_inc < SW_C;
    // Short slots hold only w_cnt_inc bits right-aligned; move them up to the MSBs.
    assign w_word     = w_short ? (w_shift_in << (SW_C - w_cnt_inc)) : w_shift_in;
    assign w_overrun  = w_cnt_inc == MAX_C;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_left_hold;
        w_sl_nxt    = r_sample_left;
        w_sr_nxt    = r_sample_right;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_short_evt = 1'b0;
        if (w_rise) begin
            case (r_state)
                HUNT: begin
                    if (r_lr_prev && !r_lr_s2) begin
                        w_state_nxt = LEFT;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                LEFT, RIGHT: begin
                    // An lr change wins over overrun: the bit at the change closes the slot.
                    if (w_lr_chg) begin
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_short_evt = w_short;
                        if (r_state == LEFT) begin
                            w_hold_nxt  = w_word;
                            w_state_nxt = RIGHT;
                        end else begin
                            w_sr_nxt    = w_word;
                            w_sl_nxt    = r_left_hold;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = LEFT;
                        end
                    end else if (w_overrun) begin
                        w_ferr_nxt  = 1'b1;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HUNT;
                    end else begin
                        w_shift_nxt = w_shift_in;
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= HUNT;
            r_bclk_s1      <= 1'b0;
            r_bclk_s2      <= 1'b0;
            r_bclk_d       <= 1'b0;
            r_lr_s1        <= 1'b0;
            r_lr_s2        <= 1'b0;
            r_lr_prev      <= 1'b0;
            r_din_s1       <= 1'b0;
            r_din_s2       <= 1'b0;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_left_hold    <= '0;
            r_sample_left  <= '0;
            r_sample_right <= '0;
            r_valid        <= 1'b0;
            r_ferr         <= 1'b0;
            r_short        <= 1'b0;
        end else begin
            r_bclk_s1      <= bit_clk;
            r_bclk_s2      <= r_bclk_s1;
            r_bclk_d       <= r_bclk_s2;
            r_lr_s1        <= frame_clk;
            r_lr_s2        <= r_lr_s1;
            r_din_s1       <= data_in;
            r_din_s2       <= r_din_s1;
            if (w_rise)
                r_lr_prev  <= r_lr_s2;
            r_state        <= w_state_nxt;
            r_shift        <= w_shift_nxt;
            r_cnt          <= w_cnt_nxt;
            r_left_hold    <= w_hold_nxt;
            r_sample_left  <= w_sl_nxt;
            r_sample_right <= w_sr_nxt;
            r_valid        <= w_valid_nxt;
            r_ferr         <= w_ferr_nxt;
            r_short        <= r_short | w_short_evt;
        end
    end

`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge clk) begin
        if (reset)
            r_err_cnt <= 8'd0;
        else if ((w_ferr_nxt || w_short_evt) && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end
    assign err_count = r_err_cnt;
`endif

    assign sample_left  = r_sample_left;
    assign sample_right = r_sample_right;
    assign sample_valid = r_valid;
    assign frame_error  = r_ferr;
    assign short_slot   = r_short;
endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: directed frames push expected pairs, a monitor pops on sample_valid.
module tb_i2s_receiver;
    logic        clk = 1'b0;
    logic        reset, bit_clk, frame_clk, data_in;
    logic [15:0] sample_left, sample_right;
    logic        sample_valid, frame_error, short_slot;

    i2s_receiver #(.SAMPLE_WIDTH(16), .MAX_SLOT(64)) dut (
        .clk(clk), .reset(reset), .bit_clk(bit_clk), .frame_clk(frame_clk),
        .data_in(data_in), .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .frame_error(frame_error), .short_slot(short_slot)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] l; logic [15:0] r;} pair_t;
    pair_t       exp_q[$];
    pair_t       e;
    int          checks = 0, errors = 0;
    int          n_valid = 0, n_ferr = 0, ferr_bit = -1, bit_idx = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] last_l = '0, last_r = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            last_l     = '0;
            last_r     = '0;
            prev_valid = 1'b0;
        end else begin
            if (sample_valid) begin
                n_valid++;
                chk("valid_width", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got L=%h R=%h expected no pulse", sample_left, sample_right);
                end else begin
                    e = exp_q.pop_front();
                    chk("left", {16'd0, sample_left}, {16'd0, e.l});
                    chk("right", {16'd0, sample_right}, {16'd0, e.r});
                end
                last_l = sample_left;
                last_r = sample_right;
            end else if (sample_left !== last_l || sample_right !== last_r) begin
                errors++;
                $display("FAIL hold: got L=%h R=%h expected L=%h R=%h", sample_left, sample_right, last_l, last_r);
            end
            if (frame_error) begin
                n_ferr++;
                ferr_bit = bit_idx;
            end
            prev_valid = sample_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 4 clk per bit: frame_clk and data change with the falling bit_clk edge.
    task automatic send_bit(input logic ws, input logic d);
        bit_clk   = 1'b0;
        frame_clk = ws;
        data_in   = d;
        bit_idx++;
        tick(2);
        bit_clk = 1'b1;
        tick(2);
    endtask

    // frame_clk switches one bit before the slot ends (I2S one-bit delay).
    task automatic send_slot(input logic ch, input logic [15:0] w, input int nbits, input int slen);
        for (int i = 0; i < slen; i++)
            send_bit((i == slen - 1) ? ~ch : ch, (i < nbits) ? w[nbits-1-i] : 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbits,
                              input int slen, input logic [15:0] el, input logic [15:0] er);
        exp_q.push_back({el, er});
        send_slot(1'b0, l, nbits, slen);
        send_slot(1'b1, r, nbits, slen);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_left", {16'd0, sample_left}, 32'd0);
        chk("rst_right", {16'd0, sample_right}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_error}, 32'd0);
        chk("rst_short", {31'd0, short_slot}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; bit_clk = 1'b0; frame_clk = 1'b0; data_in = 1'b0;
        tick(3);
        chk_zero_outputs();
        reset = 1'b0;
        tick(2);

        // Right slot first is ignored in HUNT; first pair is the following full left+right.
        send_slot(1'b1, 16'hDEAD, 16, 32);
        send_frame(16'hA5C3, 16'h5A3C, 16, 32, 16'hA5C3, 16'h5A3C);
        tick(8);
        chk("n_valid_first", n_valid, 1);
        chk("short_first", {31'd0, short_slot}, 32'd0);

        for (int i = 1; i <= 5; i++)
            send_frame(16'(i), 16'h1000 + 16'(i), 16, 32, 16'(i), 16'h1000 + 16'(i));
        tick(8);
        chk("n_valid_five", n_valid, 6);

        // 64-bit slots: the change lands on the 64th bit and must finalise, not overrun.
        send_frame(16'h1234, 16'h8765, 16, 64, 16'h1234, 16'h8765);
        tick(8);
        chk("n_valid_64", n_valid, 7);
        chk("ferr_64", n_ferr, 0);

        send_frame(16'h0FFF, 16'h0ABC, 12, 12, 16'hFFF0, 16'hABC0);
        tick(8);
        chk("short_set", {31'd0, short_slot}, 32'd1);
        send_frame(16'hBEEF, 16'hCAFE, 16, 32, 16'hBEEF, 16'hCAFE);
        tick(8);
        chk("short_sticky", {31'd0, short_slot}, 32'd1);
        chk("n_valid_short", n_valid, 9);

        // Overrun: count reaches 64 on held bit 64; pulse shows up during bit 65's period.
        bit_idx = 0;
        for (int k = 1; k <= 70; k++)
            send_bit(1'b0, 1'b1);
        tick(8);
        chk("ferr_count", n_ferr, 1);
        chk("ferr_bit", ferr_bit, 65);
        chk("n_valid_ovr", n_valid, 9);
        send_slot(1'b1, 16'h7777, 16, 32);
        send_frame(16'h1357, 16'h2468, 16, 32, 16'h1357, 16'h2468);
        tick(8);
        chk("n_valid_recover", n_valid, 10);

        // Reset mid right slot: partial left 4444 must never be published.
        send_slot(1'b0, 16'h4444, 16, 32);
        for (int k = 0; k < 10; k++)
            send_bit(1'b1, 1'b1);
        reset = 1'b1; bit_clk = 1'b0; frame_clk = 1'b0; data_in = 1'b0;
        tick(1);
        chk_zero_outputs();
        reset = 1'b0;
        tick(4);
        send_slot(1'b1, 16'h9999, 16, 32);
        send_frame(16'h0F0F, 16'hF0F0, 16, 32, 16'h0F0F, 16'hF0F0);
        tick(8);
        chk("n_valid_final", n_valid, 11);
        chk("short_after_rst", {31'd0, short_slot}, 32'd0);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
